// File: rtl/connection_block_cfg.sv
// rtl/connection_block_cfg.sv - CLB connection block with scan-loaded, commit-checked routing config
module connection_block_cfg #(
    parameter int WS     = 8,
    parameter int WD     = 8,
    parameter int WG     = 3,
    parameter int CLBIN  = 6,
    parameter int CLBOUT = 1,
    parameter int CLBOS  = 2,
    parameter int CLBOD  = 2,
    parameter int CLBX   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic              cfg_in,
    output logic              cfg_out,
    input  logic              cfg_commit,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic [WS-1:0]     single_in,
    output logic [WS-1:0]     single_out,
    output logic [WS-1:0]     single_oe,
    input  logic [WD-1:0]     double_in,
    output logic [WD-1:0]     double_out,
    output logic [WD-1:0]     double_oe,
    input  logic [WG-1:0]     global_in,
    input  logic [CLBOUT-1:0] clb0_output,
    input  logic [CLBOUT-1:0] clb1_output,
    input  logic              clb0_cout,
    input  logic              clb1_cout,
    output logic [CLBIN-1:0]  clb0_input,
    output logic [CLBIN-1:0]  clb1_input,
    output logic              clb0_cin,
    output logic              clb1_cin
);
    localparam int SRC      = WS + WD + WG + CLBX * CLBOUT;
    localparam int SEL_W    = $clog2(SRC + 1);
    localparam int OE_W     = CLBOS + CLBOD;
    localparam int OE_BASE  = 2 * CLBIN * SEL_W;
    localparam int CFG_BITS = OE_BASE + 2 * CLBOUT * OE_W;
    localparam int CNT_W    = $clog2(CFG_BITS + 2);
    localparam int WDH      = WD / 2;

    logic [CFG_BITS-1:0]   r_shreg;
    logic [CFG_BITS-1:0]   r_active;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_done;
    logic                  r_err;

    logic [2**SEL_W-1:0]   w_src0;
    logic [2**SEL_W-1:0]   w_src1;
    logic [2*CLBOUT-1:0]   w_clb_val;
    logic                  w_cnt_full;

    assign w_cnt_full = (r_cnt == CNT_W'(CFG_BITS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shreg  <= '0;
            r_active <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (cfg_en) begin
                r_shreg <= {cfg_in, r_shreg[CFG_BITS-1:1]};
            end
            // A commit judges the pre-shift state; a coincident shift is not counted.
            if (cfg_commit) begin
                r_cnt <= '0;
                if (w_cnt_full) begin
                    r_active <= r_shreg;
                    r_done   <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (cfg_en && (r_cnt != CNT_W'(CFG_BITS + 1))) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign cfg_out  = r_shreg[0];
    assign cfg_done = r_done;
    assign cfg_err  = r_err;
    assign clb0_cin = clb1_cout;
    assign clb1_cin = clb0_cout;

    // Source index 0 and anything above SRC read as constant 0.
    always_comb begin
        w_src0 = '0;
        w_src1 = '0;
        w_src0[WS:1]             = single_in;
        w_src1[WS:1]             = single_in;
        w_src0[WS+WD:WS+1]       = double_in;
        w_src1[WS+WD:WS+1]       = double_in;
        w_src0[WS+WD+WG:WS+WD+1] = global_in;
        w_src1[WS+WD+WG:WS+WD+1] = global_in;
        if (CLBX != 0) begin
            w_src0[SRC:SRC-CLBOUT+1] = clb1_output;
            w_src1[SRC:SRC-CLBOUT+1] = clb0_output;
        end
    end

    always_comb begin
        clb0_input = '0;
        clb1_input = '0;
        for (int i = 0; i < CLBIN; i++) begin
            clb0_input[i] = w_src0[r_active[i*SEL_W +: SEL_W]];
            clb1_input[i] = w_src1[r_active[(CLBIN+i)*SEL_W +: SEL_W]];
        end
    end

    assign w_clb_val = {clb1_output, clb0_output};

    // Walk drivers from highest to lowest (n,i) so the lowest enabled one lands last.
    always_comb begin
        single_oe  = '0;
        single_out = '0;
        double_oe  = '0;
        double_out = '0;
        for (int d = 2*CLBOUT-1; d >= 0; d--) begin
            for (int k = 0; k < CLBOS; k++) begin
                if (r_active[OE_BASE + d*OE_W + k]) begin
                    single_oe[(k + d*CLBOS) % WS]  = 1'b1;
                    single_out[(k + d*CLBOS) % WS] = w_clb_val[d];
                end
            end
            for (int k = 0; k < CLBOD; k++) begin
                if (r_active[OE_BASE + d*OE_W + CLBOS + k]) begin
                    double_oe[(k + d*CLBOD) % WDH]  = 1'b1;
                    double_out[(k + d*CLBOD) % WDH] = w_clb_val[d];
                end
            end
        end
    end
endmodule
